eth_tx_sched: RTL and testbench
===============================

Name: eth_tx_sched

Overview:
- Transmit scheduler for the GMII TX port. It shares one gmii_txd/gmii_tx_en output between the ARP frame sender and the UDP frame sender.
- Takes start requests from the ARP control logic and the UDP source, arbitrates with ARP priority, and enforces the inter-frame gap.
- Holds UDP traffic until ARP resolution completes (arp_done).
- Re-issues unanswered ARP requests on a timer and flags failure after a bounded number of retries.

Parameters:
- IFG_CYCLES, 12: idle gmii_txc cycles inserted after every frame.
- RETRY_CYCLES, 125000000: cycles to wait for an ARP reply after a request frame ends (1 s at 125 MHz).
- MAX_RETRY, 3: number of re-sends of an ARP request before arp_fail is set.
- TX_TIMEOUT, 4096: maximum cycles in a TX state before the done input is forced.

Ports:
- gmii_txc  in  1  TX clock; all logic is in this domain.
- rst_n  in  1  reset, synchronous, active-low.
- arp_req  in  1  one-cycle request to send an ARP frame.
- arp_req_type  in  1  0 = request, 1 = reply; sampled together with arp_req.
- udp_req  in  1  one-cycle request to send a UDP frame.
- arp_done  in  1  level; high once an ARP reply has been received.
- arp_tx_done  in  1  one-cycle pulse, ARP sender finished its frame.
- udp_tx_done  in  1  one-cycle pulse, UDP sender finished its frame.
- arp_gmii_en / arp_gmii_d  in  1/8  ARP sender GMII stream.
- udp_gmii_en / udp_gmii_d  in  1/8  UDP sender GMII stream.
- arp_tx_start  out  1  one-cycle start to the ARP sender.
- arp_tx_type  out  1  frame type for the ARP sender; held stable while in S_ARP.
- udp_tx_start  out  1  one-cycle start to the UDP sender.
- gmii_tx_en / gmii_txd  out  1/8  muxed PHY output.
- arp_fail  out  1  sticky: retries exhausted.
- busy  out  1  high whenever the state is not S_IDLE.

Behaviour:
- Reset: all outputs are 0, state S_IDLE, pending flags clear, counters 0.

Pending latches:
- arp_pend is set on arp_req; arp_pend_type is loaded from arp_req_type.
- A reply request (type 1) overwrites a pending request (type 0); the reverse does not happen.
- udp_pend is set on udp_req.
- A request arriving in the same cycle its pending flag is cleared keeps the flag set (a set wins over a clear).

States: S_IDLE, S_ARP, S_UDP, S_IFG.
- S_IDLE, arp_pend = 1: go to S_ARP. Pulse arp_tx_start the same cycle the state changes, drive arp_tx_type = arp_pend_type, clear arp_pend.
- S_IDLE, arp_pend = 0, udp_pend = 1, arp_done = 1: go to S_UDP, pulse udp_tx_start, clear udp_pend.
- udp_pend with arp_done = 0 stays pending; UDP is never dropped.
- S_ARP / S_UDP: leave on the matching done pulse, or when the timeout counter reaches TX_TIMEOUT-1. Next state is S_IFG.
- S_IFG: count IFG_CYCLES cycles, then return to S_IDLE. Pending requests are only evaluated in S_IDLE.
- Back-to-back frames: with both sources always pending, consecutive frames are spaced by exactly IFG_CYCLES idle cycles.

GMII mux:
- Registered, one cycle of latency.
- In S_ARP, gmii_tx_en <= arp_gmii_en and gmii_txd <= arp_gmii_d. S_UDP selects the UDP stream the same way.
- In any other state, gmii_tx_en <= 0 and gmii_txd <= 0.
- The select follows the state register, so a done pulse and the last data byte in the same cycle are still forwarded.

Retry timer:
- Armed when an S_ARP frame of type 0 exits; loads RETRY_CYCLES-1 and decrements.
- Disarmed and retry_cnt cleared when arp_done = 1.
- On expiry with arp_done = 0:
  - if retry_cnt < MAX_RETRY: set arp_pend with type 0 and increment retry_cnt.
  - otherwise: set arp_fail and do not re-send.
- An external arp_req of type 0 clears arp_fail and retry_cnt and disarms the timer.
- Timer expiry and an external arp_req in the same cycle produce a single pending request.

Other rules:
- A timeout exit behaves exactly like a done exit. A late done pulse arriving outside the matching TX state is ignored.
- Reset mid-frame returns to S_IDLE on the next edge and gmii_tx_en = 0 from that edge; no start is issued during reset.

Decomposition:
- Shared package eth_pkg: state encoding constants (S_IDLE, S_ARP, S_UDP, S_IFG), ARP_TYPE_REQ = 0, ARP_TYPE_REPLY = 1.
- One natural sub-module: arp_retry_timer, containing the countdown, retry_cnt and arp_fail. It outputs a one-cycle retry_req pulse and is instantiated once.

Test Plan:
- UDP gated: udp_req with arp_done = 0 -> no udp_tx_start. Raise arp_done -> udp_tx_start asserts 1 cycle after S_IDLE is reached.
- Priority and IFG: arp_req (type 1) and udp_req in the same cycle with arp_done = 1 -> arp_tx_start with arp_tx_type = 1 first. After arp_tx_done, exactly 12 idle cycles, then udp_tx_start.
- Mux latency: ARP sender drives 0x55 x7, 0xD5 -> gmii_txd shows the identical bytes delayed 1 cycle, with gmii_tx_en aligned.
- Retry: RETRY_CYCLES = 100, MAX_RETRY = 3, arp_req type 0, never reply -> 4 arp_tx_start pulses total, then arp_fail = 1. A new type-0 arp_req clears arp_fail.
- Timeout: UDP sender never pulses udp_tx_done, TX_TIMEOUT = 64 -> the scheduler leaves S_UDP after 64 cycles, runs the IFG, and busy falls.
- Reset mid-frame: assert rst_n = 0 during S_ARP -> the next edge gives gmii_tx_en = 0, arp_fail = 0, busy = 0, with no spurious start after release.

Source files
------------

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared state encoding and ARP frame type constants for the TX scheduler
package eth_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARP  = 2'd1,
        S_UDP  = 2'd2,
        S_IFG  = 2'd3
    } state_t;

    localparam logic ARP_TYPE_REQ   = 1'b0;
    localparam logic ARP_TYPE_REPLY = 1'b1;

    // Bits needed for a counter that holds 0 .. n-1.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arp_retry_timer.sv
// rtl/arp_retry_timer.sv - ARP reply timeout countdown, retry counter and sticky failure flag
module arp_retry_timer
    import eth_pkg::*;
#(
    parameter int RETRY_CYCLES = 125000000,
    parameter int MAX_RETRY    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arm,
    input  logic arp_done,
    input  logic clear,
    output logic retry_req,
    output logic arp_fail
);

    localparam int TW = cnt_width(RETRY_CYCLES);
    localparam int RW = cnt_width(MAX_RETRY + 1);

    logic [TW-1:0] cnt;
    logic [RW-1:0] retry_cnt;
    logic          armed;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            retry_cnt <= '0;
            armed     <= 1'b0;
            retry_req <= 1'b0;
            arp_fail  <= 1'b0;
        end else begin
            retry_req <= 1'b0;
            if (arp_done || clear) begin
                armed     <= 1'b0;
                retry_cnt <= '0;
                if (clear) begin
                    arp_fail <= 1'b0;
                end
            end else if (armed) begin
                if (cnt == '0) begin
                    armed <= 1'b0;
                    if (retry_cnt < RW'(MAX_RETRY)) begin
                        retry_req <= 1'b1;
                        retry_cnt <= retry_cnt + 1'b1;
                    end else begin
                        arp_fail <= 1'b1;
                    end
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
            // A request frame that just finished always restarts the wait for its reply.
            if (arm && !arp_done) begin
                armed <= 1'b1;
                cnt   <= TW'(RETRY_CYCLES - 1);
            end
        end
    end

endmodule

// File: rtl/eth_tx_sched.sv
// rtl/eth_tx_sched.sv - GMII TX scheduler arbitrating ARP and UDP senders with IFG and ARP retry
module eth_tx_sched
    import eth_pkg::*;
#(
    parameter int IFG_CYCLES   = 12,
    parameter int RETRY_CYCLES = 125000000,
    parameter int MAX_RETRY    = 3,
    parameter int TX_TIMEOUT   = 4096
) (
    input  logic       gmii_txc,
    input  logic       rst_n,
    input  logic       arp_req,
    input  logic       arp_req_type,
    input  logic       udp_req,
    input  logic       arp_done,
    input  logic       arp_tx_done,
    input  logic       udp_tx_done,
    input  logic       arp_gmii_en,
    input  logic [7:0] arp_gmii_d,
    input  logic       udp_gmii_en,
    input  logic [7:0] udp_gmii_d,
    output logic       arp_tx_start,
    output logic       arp_tx_type,
    output logic       udp_tx_start,
    output logic       gmii_tx_en,
    output logic [7:0] gmii_txd,
    output logic       arp_fail,
    output logic       busy
);

    localparam int CW = cnt_width((TX_TIMEOUT > IFG_CYCLES) ? TX_TIMEOUT : IFG_CYCLES);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          arp_pend;
    logic          arp_pend_type;
    logic          udp_pend;
    logic          retry_req;
    logic          launch_arp;
    logic          launch_udp;
    logic          in_tx;
    logic          tx_exit;
    logic          arm;
    logic          set_arp;
    logic          ext_req0;

    always_comb begin
        launch_arp = (state == S_IDLE) && arp_pend;
        launch_udp = (state == S_IDLE) && !arp_pend && udp_pend && arp_done;
        in_tx      = (state == S_ARP) || (state == S_UDP);
        tx_exit    = ((state == S_ARP) && arp_tx_done) ||
                     ((state == S_UDP) && udp_tx_done) ||
                     (in_tx && (cnt == CW'(TX_TIMEOUT - 1)));
        arm        = (state == S_ARP) && tx_exit && (arp_tx_type == ARP_TYPE_REQ);
        set_arp    = arp_req || retry_req;
        ext_req0   = arp_req && (arp_req_type == ARP_TYPE_REQ);
    end

    assign busy = (state != S_IDLE);

    arp_retry_timer #(
        .RETRY_CYCLES (RETRY_CYCLES),
        .MAX_RETRY    (MAX_RETRY)
    ) u_retry (
        .clk       (gmii_txc),
        .rst_n     (rst_n),
        .arm       (arm),
        .arp_done  (arp_done),
        .clear     (ext_req0),
        .retry_req (retry_req),
        .arp_fail  (arp_fail)
    );

    always_ff @(posedge gmii_txc) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            arp_pend      <= 1'b0;
            arp_pend_type <= ARP_TYPE_REQ;
            udp_pend      <= 1'b0;
            arp_tx_start  <= 1'b0;
            arp_tx_type   <= ARP_TYPE_REQ;
            udp_tx_start  <= 1'b0;
            gmii_tx_en    <= 1'b0;
            gmii_txd      <= 8'h00;
        end else begin
            arp_tx_start <= 1'b0;
            udp_tx_start <= 1'b0;

            // Set beats clear; a reply never gets downgraded to a request while pending.
            arp_pend <= set_arp || (arp_pend && !launch_arp);
            udp_pend <= udp_req || (udp_pend && !launch_udp);
            if (arp_req && (arp_req_type == ARP_TYPE_REPLY)) begin
                arp_pend_type <= ARP_TYPE_REPLY;
            end else if (set_arp && (!arp_pend || launch_arp)) begin
                arp_pend_type <= ARP_TYPE_REQ;
            end

            unique case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (launch_arp) begin
                        state        <= S_ARP;
                        arp_tx_start <= 1'b1;
                        arp_tx_type  <= arp_pend_type;
                    end else if (launch_udp) begin
                        state        <= S_UDP;
                        udp_tx_start <= 1'b1;
                    end
                end
                S_ARP, S_UDP: begin
                    if (tx_exit) begin
                        state <= S_IFG;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_IFG: begin
                    // The S_IDLE decision cycle is the last gap cycle, so S_IFG lasts IFG_CYCLES-1 (needs IFG_CYCLES >= 2).
                    if (cnt == CW'(IFG_CYCLES - 2)) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            unique case (state)
                S_ARP: begin
                    gmii_tx_en <= arp_gmii_en;
                    gmii_txd   <= arp_gmii_d;
                end
                S_UDP: begin
                    gmii_tx_en <= udp_gmii_en;
                    gmii_txd   <= udp_gmii_d;
                end
                default: begin
                    gmii_tx_en <= 1'b0;
                    gmii_txd   <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_sched.sv
// tb/tb_eth_tx_sched.sv - directed scoreboard bench for eth_tx_sched
module tb_eth_tx_sched;

    localparam int IFG   = 12;
    localparam int RETRY = 100;
    localparam int MAXR  = 3;
    localparam int TOUT  = 64;

    logic       clk;
    logic       rst_n;
    logic       arp_req;
    logic       arp_req_type;
    logic       udp_req;
    logic       arp_done;
    logic       arp_tx_done;
    logic       udp_tx_done;
    logic       arp_gmii_en;
    logic [7:0] arp_gmii_d;
    logic       udp_gmii_en;
    logic [7:0] udp_gmii_d;
    logic       arp_tx_start;
    logic       arp_tx_type;
    logic       udp_tx_start;
    logic       gmii_tx_en;
    logic [7:0] gmii_txd;
    logic       arp_fail;
    logic       busy;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [1:0] start_q[$];
    logic [8:0] data_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    eth_tx_sched #(
        .IFG_CYCLES   (IFG),
        .RETRY_CYCLES (RETRY),
        .MAX_RETRY    (MAXR),
        .TX_TIMEOUT   (TOUT)
    ) dut (
        .gmii_txc     (clk),
        .rst_n        (rst_n),
        .arp_req      (arp_req),
        .arp_req_type (arp_req_type),
        .udp_req      (udp_req),
        .arp_done     (arp_done),
        .arp_tx_done  (arp_tx_done),
        .udp_tx_done  (udp_tx_done),
        .arp_gmii_en  (arp_gmii_en),
        .arp_gmii_d   (arp_gmii_d),
        .udp_gmii_en  (udp_gmii_en),
        .udp_gmii_d   (udp_gmii_d),
        .arp_tx_start (arp_tx_start),
        .arp_tx_type  (arp_tx_type),
        .udp_tx_start (udp_tx_start),
        .gmii_tx_en   (gmii_tx_en),
        .gmii_txd     (gmii_txd),
        .arp_fail     (arp_fail),
        .busy         (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Expected start kind is {is_udp, arp_type}.
    task automatic wait_start(input int limit, output int k);
        logic [1:0] kind;
        logic [1:0] exp_kind;
        k = 0;
        while (!(arp_tx_start || udp_tx_start) && k < limit) begin
            tick();
            k++;
        end
        check_bit("start_seen", arp_tx_start || udp_tx_start, 1'b1);
        kind     = {udp_tx_start, udp_tx_start ? 1'b0 : arp_tx_type};
        exp_kind = start_q.pop_front();
        check_val("start_kind", {30'b0, kind}, {30'b0, exp_kind});
    endtask

    task automatic wait_idle(input int limit);
        int k;
        k = 0;
        while (busy && k < limit) begin
            tick();
            k++;
        end
        check_bit("idle_reached", busy, 1'b0);
    endtask

    // Called in the start cycle; sender drives from that cycle, done with the last byte.
    task automatic send_frame(input bit udp, input int n);
        logic [7:0] b;
        logic [8:0] exp;
        for (int i = 0; i <= n; i++) begin
            if (i > 0) begin
                exp = data_q.pop_front();
                check_val(udp ? "udp_mux" : "arp_mux", {23'b0, gmii_tx_en, gmii_txd}, {23'b0, exp});
            end
            b = udp ? (8'hA0 + i[7:0]) : ((i == n - 1) ? 8'hD5 : 8'h55);
            if (i < n) begin
                if (udp) begin
                    udp_gmii_en = 1'b1;
                    udp_gmii_d  = b;
                    udp_tx_done = (i == n - 1);
                end else begin
                    arp_gmii_en = 1'b1;
                    arp_gmii_d  = b;
                    arp_tx_done = (i == n - 1);
                end
                data_q.push_back({1'b1, b});
            end else begin
                udp_gmii_en = 1'b0;
                udp_gmii_d  = 8'h00;
                udp_tx_done = 1'b0;
                arp_gmii_en = 1'b0;
                arp_gmii_d  = 8'h00;
                arp_tx_done = 1'b0;
            end
            tick();
        end
        check_bit("mux_idle_after_frame", gmii_tx_en, 1'b0);
    endtask

    initial begin
        int k;
        int n;
        rst_n        = 1'b0;
        arp_req      = 1'b0;
        arp_req_type = 1'b0;
        udp_req      = 1'b0;
        arp_done     = 1'b0;
        arp_tx_done  = 1'b0;
        udp_tx_done  = 1'b0;
        arp_gmii_en  = 1'b0;
        arp_gmii_d   = 8'h00;
        udp_gmii_en  = 1'b0;
        udp_gmii_d   = 8'h00;
        repeat (3) tick();

        check_bit("rst_gmii_tx_en", gmii_tx_en, 1'b0);
        check_val("rst_gmii_txd", {24'b0, gmii_txd}, 32'h0);
        check_bit("rst_arp_tx_start", arp_tx_start, 1'b0);
        check_bit("rst_udp_tx_start", udp_tx_start, 1'b0);
        check_bit("rst_arp_tx_type", arp_tx_type, 1'b0);
        check_bit("rst_arp_fail", arp_fail, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        tick();

        // UDP held until ARP resolved
        udp_req = 1'b1;
        tick();
        udp_req = 1'b0;
        n = 0;
        repeat (20) begin
            if (udp_tx_start) n++;
            tick();
        end
        check_val("udp_gated_starts", n, 0);
        check_bit("udp_gated_busy", busy, 1'b0);
        start_q.push_back(2'b10);
        arp_done = 1'b1;
        tick();
        wait_start(0, k);
        send_frame(1'b1, 4);
        wait_idle(50);

        // ARP reply wins over UDP, then exact inter-frame gap
        start_q.push_back(2'b01);
        start_q.push_back(2'b10);
        arp_req      = 1'b1;
        arp_req_type = 1'b1;
        udp_req      = 1'b1;
        tick();
        arp_req      = 1'b0;
        arp_req_type = 1'b0;
        udp_req      = 1'b0;
        wait_start(10, k);
        check_bit("prio_no_udp_start", udp_tx_start, 1'b0);
        send_frame(1'b0, 8);
        wait_start(50, k);
        check_val("ifg_done_to_start", k + 2, IFG + 1);
        send_frame(1'b1, 6);
        wait_idle(50);

        // UDP sender never finishes: timeout exit then IFG
        start_q.push_back(2'b10);
        udp_req = 1'b1;
        tick();
        udp_req = 1'b0;
        wait_start(10, k);
        n = 0;
        while (busy && n < 500) begin
            n++;
            tick();
        end
        check_val("timeout_busy_cycles", n, TOUT + IFG - 1);

        // Late done pulses outside TX states are ignored
        arp_tx_done = 1'b1;
        udp_tx_done = 1'b1;
        tick();
        arp_tx_done = 1'b0;
        udp_tx_done = 1'b0;
        repeat (3) tick();
        check_bit("late_done_ignored", busy, 1'b0);

        // Unanswered request: 1 + MAXR frames, then failure
        arp_done = 1'b0;
        repeat (MAXR + 1) start_q.push_back(2'b00);
        arp_req      = 1'b1;
        arp_req_type = 1'b0;
        tick();
        arp_req = 1'b0;
        for (int r = 0; r <= MAXR; r++) begin
            wait_start(400, k);
            send_frame(1'b0, 8);
        end
        n = 0;
        while (!arp_fail && n < 400) begin
            n++;
            tick();
        end
        check_bit("arp_fail_set", arp_fail, 1'b1);
        n = 0;
        repeat (2 * RETRY) begin
            if (arp_tx_start) n++;
            tick();
        end
        check_val("no_resend_after_fail", n, 0);

        start_q.push_back(2'b00);
        arp_req      = 1'b1;
        arp_req_type = 1'b0;
        tick();
        arp_req = 1'b0;
        check_bit("arp_fail_cleared", arp_fail, 1'b0);
        arp_done = 1'b1;
        wait_start(10, k);
        send_frame(1'b0, 8);
        wait_idle(50);

        // Reset in the middle of an ARP frame
        start_q.push_back(2'b01);
        arp_req      = 1'b1;
        arp_req_type = 1'b1;
        tick();
        arp_req      = 1'b0;
        arp_req_type = 1'b0;
        wait_start(10, k);
        arp_gmii_en = 1'b1;
        arp_gmii_d  = 8'h55;
        tick();
        tick();
        check_bit("mid_frame_en", gmii_tx_en, 1'b1);
        rst_n = 1'b0;
        tick();
        check_bit("rst_mid_gmii_tx_en", gmii_tx_en, 1'b0);
        check_bit("rst_mid_busy", busy, 1'b0);
        check_bit("rst_mid_arp_fail", arp_fail, 1'b0);
        check_bit("rst_mid_arp_tx_start", arp_tx_start, 1'b0);
        arp_gmii_en = 1'b0;
        arp_gmii_d  = 8'h00;
        rst_n       = 1'b1;
        n = 0;
        repeat (20) begin
            if (arp_tx_start || udp_tx_start) n++;
            tick();
        end
        check_val("no_start_after_reset", n, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
